// File: rtl/mcdt_formatter.sv
// mcdt_formatter
//   Downstream formatter for the multi-channel data transfer (mcdt) stream.
//   Words arriving on the unflow-controlled mcdt stream are buffered in one
//   FIFO per channel (ids 0..2). When a channel holds at least one packet's
//   worth of words, a round-robin arbiter selects it, the block requests the
//   downstream bus and, once granted, emits a fixed-length burst tagged with
//   channel id and length.
//
// Ports
//   clk_i         clock, rising edge
//   rstn_i        asynchronous active-low reset
//   mcdt_data_i   data word from mcdt
//   mcdt_val_i    data word valid (no backpressure)
//   mcdt_id_i     source channel 0..2 (3 is dropped silently)
//   pkt_len_i     packet length select: 00=4, 01=8, 10=16, 11=32 words
//   fmt_req_o     packet request to downstream
//   fmt_grant_i   downstream grant (honoured only while requesting)
//   fmt_chid_o    channel id of current packet (0 when idle)
//   fmt_length_o  word count of current packet (0 when idle)
//   fmt_data_o    packet data word (0 outside a burst)
//   fmt_start_o   first word of packet
//   fmt_end_o     last word of packet
//   ovf_o         sticky per-channel overflow flags
module mcdt_formatter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] mcdt_data_i,
  input  logic          mcdt_val_i,
  input  logic [1:0]    mcdt_id_i,
  input  logic [1:0]    pkt_len_i,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  output logic [1:0]    fmt_chid_o,
  output logic [5:0]    fmt_length_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o,
  output logic [2:0]    ovf_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned NCH = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND
  } state_e;

  state_e        state_q;
  logic [1:0]    last_q;
  logic [1:0]    chid_q;
  logic [5:0]    len_q;
  logic [5:0]    wcnt_q;
  logic          req_q;
  logic          start_q;
  logic          end_q;

  logic [5:0]    len_dec;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] elig;
  logic [DW-1:0] head [NCH];
  logic [DW-1:0] head_sel;
  logic [1:0]    pick;
  logic          pick_vld;

  assign len_dec = 6'd4 << pkt_len_i;

  // Per-channel FIFO: storage, pointers, occupancy and sticky overflow flag.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [1:0] ID = 2'(c);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;

    assign push[c]   = mcdt_val_i && (mcdt_id_i == ID);
    assign pop[c]    = (state_q == SEND) && (chid_q == ID);
    // A full FIFO still takes the word when it is drained on the same edge.
    assign accept[c] = push[c] && ((cnt_q != CW'(DEPTH)) || pop[c]);
    assign elig[c]   = (cnt_q >= CW'(len_dec));
    assign head[c]   = mem_q[rptr_q];
    assign ovf_o[c]  = ovf_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (accept[c]) wptr_q <= wptr_q + 1'b1;
        if (pop[c])    rptr_q <= rptr_q + 1'b1;
        case ({accept[c], pop[c]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
        if (push[c] && !accept[c]) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (accept[c]) mem_q[wptr_q] <= mcdt_data_i;
    end
  end

  // Round-robin: search starts at the channel after the last one served.
  always_comb begin
    pick_vld = |elig;
    pick     = '0;
    case (last_q)
      2'd0: begin
        if      (elig[1]) pick = 2'd1;
        else if (elig[2]) pick = 2'd2;
        else              pick = 2'd0;
      end
      2'd1: begin
        if      (elig[2]) pick = 2'd2;
        else if (elig[0]) pick = 2'd0;
        else              pick = 2'd1;
      end
      default: begin
        if      (elig[0]) pick = 2'd0;
        else if (elig[1]) pick = 2'd1;
        else              pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    head_sel = '0;
    case (chid_q)
      2'd0:    head_sel = head[0];
      2'd1:    head_sel = head[1];
      default: head_sel = head[2];
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      chid_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            chid_q  <= pick;
            len_q   <= len_dec;
            last_q  <= pick;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (fmt_grant_i) begin
            req_q   <= 1'b0;
            start_q <= 1'b1;
            end_q   <= 1'b0;
            wcnt_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          start_q <= 1'b0;
          if (wcnt_q == len_q - 6'd1) begin
            end_q   <= 1'b0;
            chid_q  <= '0;
            len_q   <= '0;
            state_q <= IDLE;
          end else begin
            wcnt_q <= wcnt_q + 6'd1;
            // wcnt_q indexes the word on the bus now; flag the one after it.
            end_q  <= (wcnt_q + 6'd2 == len_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fmt_req_o    = req_q;
  assign fmt_chid_o   = chid_q;
  assign fmt_length_o = len_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;
  assign fmt_data_o   = (state_q == SEND) ? head_sel : '0;

endmodule
